// File: rtl/id_stage.sv
// Instruction decode stage.
// This stage decodes one 8-bit instruction per cycle and reads the 8-entry
// register file. A read returns the writeback data in the same cycle when the
// writeback targets the register being read.
// A jump redirects fetch combinationally. The stage then squashes the next
// FLUSH_CYCLES instructions, which came from the wrong path.
// Decoded operands are registered into the ID/EX boundary.
module id_stage #(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        inst_code_in,
  input  logic [7:0]        PCline_in,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [7:0]        PC_j,
  output logic              PCsrc,
  output logic [1:0]        ex_op,
  output logic [2:0]        ex_rd_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rd_data,
  output logic              ex_valid
);

  localparam int         NUM_REGS   = 8;
  localparam logic [1:0] OP_MOV     = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b01;
  localparam logic [1:0] OP_JMP     = 2'b11;
  // The squash counter is two bits wide, so FLUSH_CYCLES can be 1, 2 or 3.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  // Instruction fields
  logic [1:0] op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [5:0] off;

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rd_data;

  // Squash tracking
  logic [1:0] flush_cnt_q;
  logic [1:0] flush_cnt_d;
  logic       squash;
  logic       jump_taken;

  // ID/EX boundary
  logic [1:0]        ex_op_q;
  logic [1:0]        ex_op_d;
  logic [2:0]        ex_rd_addr_q;
  logic [2:0]        ex_rd_addr_d;
  logic [DATA_W-1:0] ex_rs_data_q;
  logic [DATA_W-1:0] ex_rs_data_d;
  logic [DATA_W-1:0] ex_rd_data_q;
  logic [DATA_W-1:0] ex_rd_data_d;
  logic              ex_valid_q;
  logic              ex_valid_d;

  // Split the instruction into fields; the jump offset overlaps rd/rs
  always_comb begin
    op  = inst_code_in[7:6];
    rd  = inst_code_in[5:3];
    rs  = inst_code_in[2:0];
    off = inst_code_in[5:0];
  end

  // Per-entry next value: writeback replaces the entry, otherwise it holds
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf_next
      assign rf_d[gi] = (wb_en && (wb_addr == 3'(gi))) ? wb_data : rf_q[gi];
    end
  endgenerate

  // Register file storage; reset restores the identity pattern reg[i] = i
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        rf_q[i] <= DATA_W'(i);
      end else begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // rf_d already contains this cycle's writeback. Reading from it gives the
  // write-through bypass without a separate compare.
  always_comb begin
    rs_data = rf_d[rs];
    rd_data = rf_d[rd];
  end

  // Jump resolution. A squashed JMP must not redirect fetch, and reset forces
  // the fetch interface to a quiet state.
  always_comb begin
    squash     = (flush_cnt_q != 2'd0);
    jump_taken = !reset && (op == OP_JMP) && !squash;
    PCsrc      = !jump_taken;
    if (reset) begin
      PC_j = 8'h00;
    end else begin
      PC_j = PCline_in + {{2{off[5]}}, off};
    end
  end

  // Squash counter next state. A taken jump arms the counter, and each
  // squashed slot counts it down. A squashed jump never re-arms it.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (jump_taken) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (squash) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end
  end

  // Squash counter register; reset cancels any pending squash
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_q <= 2'd0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // ID/EX next values. The data fields always carry the decoded values, so
  // an invalid slot still holds defined data.
  always_comb begin
    ex_op_d      = op;
    ex_rd_addr_d = rd;
    ex_rs_data_d = rs_data;
    ex_rd_data_d = rd_data;
    ex_valid_d   = !squash && ((op == OP_MOV) || (op == OP_ADD));
  end

  // ID/EX register, loaded every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_op_q      <= 2'd0;
      ex_rd_addr_q <= 3'd0;
      ex_rs_data_q <= '0;
      ex_rd_data_q <= '0;
      ex_valid_q   <= 1'b0;
    end else begin
      ex_op_q      <= ex_op_d;
      ex_rd_addr_q <= ex_rd_addr_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rd_data_q <= ex_rd_data_d;
      ex_valid_q   <= ex_valid_d;
    end
  end

  // Drive the ID/EX outputs from their flops
  always_comb begin
    ex_op      = ex_op_q;
    ex_rd_addr = ex_rd_addr_q;
    ex_rs_data = ex_rs_data_q;
    ex_rd_data = ex_rd_data_q;
    ex_valid   = ex_valid_q;
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage.
// The stimulus checks the combinational fetch redirect (PCsrc/PC_j) before
// each edge. It also queues the ID/EX contents expected after that edge.
// A monitor pops the queue after every edge and compares.
module tb_id_stage;

  logic       clk;
  logic       reset;
  logic [7:0] inst_code_in;
  logic [7:0] PCline_in;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [7:0] PC_j;
  logic       PCsrc;
  logic [1:0] ex_op;
  logic [2:0] ex_rd_addr;
  logic [7:0] ex_rs_data;
  logic [7:0] ex_rd_data;
  logic       ex_valid;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [2:0] rd;
    logic [7:0] rs_data;
    logic [7:0] rd_data;
    bit         chk_data;
  } exp_t;

  exp_t sb_q[$];

  id_stage #(
    .DATA_W      (8),
    .FLUSH_CYCLES(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_code_in(inst_code_in),
    .PCline_in   (PCline_in),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .PC_j        (PC_j),
    .PCsrc       (PCsrc),
    .ex_op       (ex_op),
    .ex_rd_addr  (ex_rd_addr),
    .ex_rs_data  (ex_rs_data),
    .ex_rd_data  (ex_rd_data),
    .ex_valid    (ex_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after each edge, compare the ID/EX register with the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      txn++;
      $display("txn %0d: ex_valid=%0b ex_op=%0d ex_rd_addr=%0d ex_rs_data=%02h ex_rd_data=%02h",
               txn, ex_valid, ex_op, ex_rd_addr, ex_rs_data, ex_rd_data);
      checks++;
      if (ex_valid !== e.v) begin
        failures++;
        $display("FAIL txn%0d ex_valid: got %0b expected %0b", txn, ex_valid, e.v);
      end
      if (e.chk_data) begin
        checks++;
        if (ex_op !== e.op || ex_rd_addr !== e.rd ||
            ex_rs_data !== e.rs_data || ex_rd_data !== e.rd_data) begin
          failures++;
          $display("FAIL txn%0d ex_fields: got op=%0d rd=%0d rs_data=%02h rd_data=%02h expected op=%0d rd=%0d rs_data=%02h rd_data=%02h",
                   txn, ex_op, ex_rd_addr, ex_rs_data, ex_rd_data,
                   e.op, e.rd, e.rs_data, e.rd_data);
        end
      end
    end
  end

  // One cycle of stimulus: drive inputs, check redirect, queue expected ID/EX contents
  task automatic step(input logic rst, input logic [7:0] inst, input logic [7:0] pcl,
                      input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic exp_pcsrc, input logic [7:0] exp_pcj,
                      input logic ev, input logic [1:0] eop, input logic [2:0] erd,
                      input logic [7:0] ers, input logic [7:0] erdd, input bit chk);
    exp_t e;
    reset        = rst;
    inst_code_in = inst;
    PCline_in    = pcl;
    wb_en        = we;
    wb_addr      = wa;
    wb_data      = wd;
    #1;
    checks++;
    if (PCsrc !== exp_pcsrc || PC_j !== exp_pcj) begin
      failures++;
      $display("FAIL redirect inst=%02h pcl=%02h: got PCsrc=%0b PC_j=%02h expected PCsrc=%0b PC_j=%02h",
               inst, pcl, PCsrc, PC_j, exp_pcsrc, exp_pcj);
    end
    e.v        = ev;
    e.op       = eop;
    e.rd       = erd;
    e.rs_data  = ers;
    e.rd_data  = erdd;
    e.chk_data = chk;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    inst_code_in = 8'h00;
    PCline_in    = 8'h00;
    wb_en        = 1'b0;
    wb_addr      = 3'd0;
    wb_data      = 8'h00;

    // Reset: redirect forced quiet, ID/EX cleared, even with a JMP presented
    step(1, 8'h4A, 8'h00, 0, 3'd0, 8'h00, 1, 8'h00, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1);
    step(1, 8'h4A, 8'h00, 0, 3'd0, 8'h00, 1, 8'h00, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1);
    step(1, 8'hFD, 8'h02, 0, 3'd0, 8'h00, 1, 8'h00, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1);

    // MOV r0,ri reads every register's reset value
    for (int i = 0; i < 8; i++) begin
      step(0, 8'(i), 8'h10, 0, 3'd0, 8'h00, 1, 8'(8'h10 + i),
           1, 2'd0, 3'd0, 8'(i), 8'h00, 1);
    end

    // MOV r1,r3
    step(0, 8'h0B, 8'h20, 0, 3'd0, 8'h00, 1, 8'h2B, 1, 2'd0, 3'd1, 8'h03, 8'h01, 1);
    // ADD r1,r2 with same-cycle writeback of r2
    step(0, 8'h4A, 8'h20, 1, 3'd2, 8'h55, 1, 8'h2A, 1, 2'd1, 3'd1, 8'h55, 8'h01, 1);
    // MOV r3,r2 sees the stored value
    step(0, 8'h1A, 8'h21, 0, 3'd0, 8'h00, 1, 8'h3B, 1, 2'd0, 3'd3, 8'h55, 8'h03, 1);
    // r0 is writable; bypass on both read ports
    step(0, 8'h00, 8'h22, 1, 3'd0, 8'hA5, 1, 8'h22, 1, 2'd0, 3'd0, 8'hA5, 8'hA5, 1);
    // MOV r4,r0 (offset field reads as -32)
    step(0, 8'h20, 8'h23, 0, 3'd0, 8'h00, 1, 8'h03, 1, 2'd0, 3'd4, 8'hA5, 8'h04, 1);
    // NOP is not valid
    step(0, 8'h80, 8'h24, 0, 3'd0, 8'h00, 1, 8'h24, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);

    // JMP -3 from 0x02 wraps to 0xFF; next instruction squashed, then live
    step(0, 8'hFD, 8'h02, 0, 3'd0, 8'h00, 0, 8'hFF, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'h0B, 8'h03, 0, 3'd0, 8'h00, 1, 8'h0E, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'h0B, 8'h04, 0, 3'd0, 8'h00, 1, 8'h0F, 1, 2'd0, 3'd1, 8'h03, 8'h01, 1);

    // Back-to-back jumps: second is squashed and does not re-arm the squash
    step(0, 8'hC4, 8'h10, 0, 3'd0, 8'h00, 0, 8'h14, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'hC8, 8'h11, 0, 3'd0, 8'h00, 1, 8'h19, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'hC2, 8'h12, 0, 3'd0, 8'h00, 0, 8'h14, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'h4B, 8'h13, 0, 3'd0, 8'h00, 1, 8'h1E, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'h4B, 8'h14, 0, 3'd0, 8'h00, 1, 8'h1F, 1, 2'd1, 3'd1, 8'h03, 8'h01, 1);

    // Offset extremes: +31 wrapping upward, -32
    step(0, 8'hDF, 8'hF0, 0, 3'd0, 8'h00, 0, 8'h0F, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'h80, 8'hF1, 0, 3'd0, 8'h00, 1, 8'hF1, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'hE0, 8'h05, 0, 3'd0, 8'h00, 0, 8'hE5, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 8'h2D, 8'h06, 0, 3'd0, 8'h00, 1, 8'hF3, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);

    // Reset mid-squash, with a colliding writeback that reset must override
    step(0, 8'hC4, 8'h30, 0, 3'd0, 8'h00, 0, 8'h34, 0, 2'd0, 3'd0, 8'h00, 8'h00, 0);
    step(1, 8'h0B, 8'h31, 1, 3'd2, 8'h77, 1, 8'h00, 0, 2'd0, 3'd0, 8'h00, 8'h00, 1);
    step(0, 8'h0A, 8'h40, 0, 3'd0, 8'h00, 1, 8'h4A, 1, 2'd0, 3'd1, 8'h02, 8'h01, 1);
    step(0, 8'h00, 8'h41, 0, 3'd0, 8'h00, 1, 8'h41, 1, 2'd0, 3'd0, 8'h00, 8'h00, 1);

    // Drain and confirm every expectation was consumed
    inst_code_in = 8'h80;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
